// File: rtl/button_debounce_pkg.sv
// Shared types and build constants for the push-button conditioning stage.
package button_pkg;

  // Debouncer FSM states.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,  // stable released
    PRESS_WAIT   = 2'd1,  // pressed level seen, waiting for it to stay
    HELD         = 2'd2,  // stable pressed
    RELEASE_WAIT = 2'd3   // released level seen, waiting for it to stay
  } btn_state_e;

  // Width of the wrapping press counter.
  localparam int unsigned PRESS_COUNT_W = 8;

  // 12 MHz ICE_CLK build: 20 ms debounce, 1 s long press.
  localparam int unsigned DEBOUNCE_CYCLES_12MHZ = 240_000;
  localparam int unsigned LONG_CYCLES_12MHZ     = 12_000_000;

  // 48 MHz ICE_CLK build: 20 ms debounce, 1 s long press.
  localparam int unsigned DEBOUNCE_CYCLES_48MHZ = 960_000;
  localparam int unsigned LONG_CYCLES_48MHZ     = 48_000_000;

endpackage

// File: rtl/button_debounce_if.sv
// Button pad in, conditioned level/events out.
// master: the conditioning stage; slave: the pad driver / event consumer.
interface button_debounce_if;
  import button_pkg::*;

  logic                     btn_raw;
  logic                     pressed;
  logic                     press_pulse;
  logic                     release_pulse;
  logic                     long_pulse;
  logic                     long_active;
  logic [PRESS_COUNT_W-1:0] press_count;

  modport master (
    input  btn_raw,
    output pressed, press_pulse, release_pulse, long_pulse, long_active, press_count
  );

  modport slave (
    output btn_raw,
    input  pressed, press_pulse, release_pulse, long_pulse, long_active, press_count
  );

endinterface

// File: rtl/button_debounce_sync_ff.sv
// N-flop synchroniser for a single asynchronous input; reusable for any pad.
module sync_ff #(
  parameter int unsigned STAGES    = 2,     // >= 2
  parameter logic        RESET_VAL = 1'b0   // idle level of the pad
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the pad through the chain; reset loads the idle level so no
  // phantom edge is seen when reset releases.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples the pre-edge
    // value of its neighbour; blocking here would collapse the chain.
    if (rst) chain <= {STAGES{RESET_VAL}};
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: synchronise, debounce, and derive press/release/
// long-press events plus a wrapping press counter. All outputs registered.
module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_12MHZ,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_12MHZ,
  parameter logic        ACTIVE_LEVEL    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  button_debounce_if.master bus
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

  // The sample that enters a WAIT state is the first of the run, so the
  // run is complete when the counter has seen DEBOUNCE_CYCLES-2 more.
  localparam logic [DB_W-1:0] DB_LAST =
    DB_W'((DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0);
  // With a one-sample debounce the first differing sample is accepted
  // directly, bypassing the WAIT states.
  localparam logic ACCEPT_FIRST = (DEBOUNCE_CYCLES == 1);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYCLES - 1);

  logic                     pad_sync;
  logic                     s;
  btn_state_e               state;
  logic [DB_W-1:0]          db_cnt;
  logic [HOLD_W-1:0]        hold_cnt;
  logic                     press_accept;
  logic                     release_accept;
  logic                     hold_step;

  logic                     pressed_q;
  logic                     press_pulse_q;
  logic                     release_pulse_q;
  logic                     long_pulse_q;
  logic                     long_active_q;
  logic [PRESS_COUNT_W-1:0] press_count_q;

  sync_ff #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (~ACTIVE_LEVEL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.btn_raw),
    .q   (pad_sync)
  );

  // Normalised sample: 1 means pressed regardless of pad polarity.
  assign s = (pad_sync == ACTIVE_LEVEL);

  // Decode the accepting transitions once so the state register and the
  // output/counter updates agree on the same edge.
  assign press_accept   = s  && ((state == IDLE       && ACCEPT_FIRST) ||
                                 (state == PRESS_WAIT && db_cnt == DB_LAST));
  assign release_accept = !s && ((state == HELD         && ACCEPT_FIRST) ||
                                 (state == RELEASE_WAIT && db_cnt == DB_LAST));
  assign hold_step      = (state == HELD || state == RELEASE_WAIT) && !release_accept;

  // FSM, debounce/hold counters and registered outputs in one clocked block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      db_cnt          <= '0;
      hold_cnt        <= '0;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      long_pulse_q    <= 1'b0;
      long_active_q   <= 1'b0;
      press_count_q   <= '0;
    end else begin
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      long_pulse_q    <= 1'b0;

      case (state)
        IDLE: begin
          if (s) begin
            db_cnt <= '0;
            state  <= press_accept ? HELD : PRESS_WAIT;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state  <= IDLE;
            db_cnt <= '0;
          end else if (press_accept) begin
            state  <= HELD;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        HELD: begin
          if (!s) begin
            db_cnt <= '0;
            state  <= release_accept ? IDLE : RELEASE_WAIT;
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            state  <= HELD;
            db_cnt <= '0;
          end else if (release_accept) begin
            state  <= IDLE;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          db_cnt <= '0;
        end
      endcase

      if (press_accept) begin
        pressed_q     <= 1'b1;
        press_pulse_q <= 1'b1;
        press_count_q <= press_count_q + PRESS_COUNT_W'(1);
        hold_cnt      <= '0;
      end

      if (release_accept) begin
        pressed_q       <= 1'b0;
        release_pulse_q <= 1'b1;
        long_active_q   <= 1'b0;
      end

      // Hold time keeps running through release bounces; saturation makes
      // the long event fire at most once per press.
      if (hold_step && hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
        if (hold_cnt == HOLD_PRE) begin
          long_pulse_q  <= 1'b1;
          long_active_q <= 1'b1;
        end
      end
    end
  end

  assign bus.pressed       = pressed_q;
  assign bus.press_pulse   = press_pulse_q;
  assign bus.release_pulse = release_pulse_q;
  assign bus.long_pulse    = long_pulse_q;
  assign bus.long_active   = long_active_q;
  assign bus.press_count   = press_count_q;

endmodule
